// File: rtl/game_round_controller_if.sv
// Session-level signals between the game round controller, the per-shot FSM
// and the display/sprite datapath. The controller sits on the master side.
interface game_round_controller_if #(
    parameter int SCORE_W = 8,
    parameter int LIVES_W = 2,
    parameter int LEVEL_W = 3,
    parameter int SPEED_W = 4
);
    logic               key;
    logic               round_end;
    logic               round_won;
    logic               game_enable;
    logic               new_game;
    logic               level_up;
    logic               game_over;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic [LEVEL_W-1:0] level;
    logic [SPEED_W-1:0] target_speed;
    logic [4:0]         dbg_state;

    // round_end is a one-cycle pulse; round_won is meaningful only while round_end=1.
    modport master (
        input  key, round_end, round_won,
        output game_enable, new_game, level_up, game_over,
        output score, lives, level, target_speed, dbg_state
    );

    modport slave (
        output key, round_end, round_won,
        input  game_enable, new_game, level_up, game_over,
        input  score, lives, level, target_speed, dbg_state
    );
endinterface

// File: rtl/game_round_controller.sv
// Game session controller: start on key, score/lives/level bookkeeping,
// target speed per level and a minimum hold on the game-over screen.
module game_round_controller #(
    parameter int SCORE_W        = 8,
    parameter int N_LIVES        = 3,
    parameter int LIVES_W        = 2,
    parameter int LEVEL_W        = 3,
    parameter int MAX_LEVEL      = 7,
    parameter int WINS_PER_LEVEL = 4,
    parameter int SPEED_W        = 4,
    parameter int BASE_SPEED     = 1,
    parameter int GAME_OVER_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    game_round_controller_if.master bus
);
    localparam int WIN_W     = (WINS_PER_LEVEL > 1) ? $clog2(WINS_PER_LEVEL) : 1;
    localparam int HOLD_W    = $clog2(GAME_OVER_HOLD + 1);
    localparam int SPEED_MAX = (1 << SPEED_W) - 1;

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        INIT      = 5'b00010,
        PLAY      = 5'b00100,
        LEVEL_UP  = 5'b01000,
        GAME_OVER = 5'b10000
    } state_t;

    state_t             state;
    logic               key_q;
    logic               key_rise;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic [LEVEL_W-1:0] level;
    logic [WIN_W-1:0]   win_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [SPEED_W-1:0] target_speed;

    assign key_rise = bus.key & ~key_q;

    function automatic logic [SPEED_W-1:0] speed_for(input logic [LEVEL_W-1:0] lvl);
        int sum;
        sum = BASE_SPEED + int'(lvl);
        if (sum > SPEED_MAX) return '1;
        return SPEED_W'(sum);
    endfunction

    // target_speed is loaded together with level so it is already valid in LEVEL_UP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            key_q        <= 1'b0;
            score        <= '0;
            lives        <= '0;
            level        <= '0;
            win_cnt      <= '0;
            hold_cnt     <= '0;
            target_speed <= SPEED_W'(BASE_SPEED);
        end else begin
            key_q <= bus.key;
            case (state)
                IDLE: begin
                    if (key_rise) state <= INIT;
                end
                INIT: begin
                    score        <= '0;
                    lives        <= LIVES_W'(N_LIVES);
                    level        <= '0;
                    win_cnt      <= '0;
                    target_speed <= speed_for('0);
                    state        <= PLAY;
                end
                PLAY: begin
                    if (bus.round_end) begin
                        if (bus.round_won) begin
                            if (score != '1) score <= score + 1'b1;
                            if (win_cnt == WIN_W'(WINS_PER_LEVEL - 1)) begin
                                win_cnt <= '0;
                                if (level < LEVEL_W'(MAX_LEVEL)) begin
                                    level        <= level + 1'b1;
                                    target_speed <= speed_for(level + 1'b1);
                                    state        <= LEVEL_UP;
                                end
                            end else begin
                                win_cnt <= win_cnt + 1'b1;
                            end
                        end else if (lives == LIVES_W'(1)) begin
                            lives    <= '0;
                            hold_cnt <= '0;
                            state    <= GAME_OVER;
                        end else begin
                            lives <= lives - 1'b1;
                        end
                    end
                end
                LEVEL_UP: begin
                    state <= PLAY;
                end
                GAME_OVER: begin
                    if (key_rise && hold_cnt == HOLD_W'(GAME_OVER_HOLD)) begin
                        state <= INIT;
                    end else if (hold_cnt != HOLD_W'(GAME_OVER_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.game_enable  = (state == PLAY);
    assign bus.new_game     = (state == INIT);
    assign bus.level_up     = (state == LEVEL_UP);
    assign bus.game_over    = (state == GAME_OVER);
    assign bus.score        = score;
    assign bus.lives        = lives;
    assign bus.level        = level;
    assign bus.target_speed = target_speed;
    assign bus.dbg_state    = state;
endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: a default instance and a saturation-sized
// instance share stimulus and are checked every cycle against a session model.
module tb_game_round_controller;
    localparam int N_LIVES = 3;
    localparam int MAX_LVL = 7;
    localparam int HOLD    = 16;
    localparam int BASE    = 1;
    localparam int SPMAX   = 15;

    localparam int M_IDLE = 0, M_INIT = 1, M_PLAY = 2, M_LVL = 3, M_OVER = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    game_round_controller_if #(.SCORE_W(8), .LIVES_W(2), .LEVEL_W(3), .SPEED_W(4)) bus0 ();
    game_round_controller_if #(.SCORE_W(3), .LIVES_W(2), .LEVEL_W(3), .SPEED_W(4)) bus1 ();

    game_round_controller #(
        .SCORE_W(8), .N_LIVES(3), .LIVES_W(2), .LEVEL_W(3), .MAX_LEVEL(7),
        .WINS_PER_LEVEL(4), .SPEED_W(4), .BASE_SPEED(1), .GAME_OVER_HOLD(16)
    ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    game_round_controller #(
        .SCORE_W(3), .N_LIVES(3), .LIVES_W(2), .LEVEL_W(3), .MAX_LEVEL(7),
        .WINS_PER_LEVEL(1), .SPEED_W(4), .BASE_SPEED(1), .GAME_OVER_HOLD(16)
    ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    int cfg_sw[2]  = '{8, 3};
    int cfg_wpl[2] = '{4, 1};

    // session model: counts of wins/lives per game, level derived from wins
    int m_mode[2];
    int m_wins[2];
    int m_lives[2];
    int m_hold[2];
    int m_keyq;

    logic key, re, rw;
    int   ng_cnt0, lu_cnt1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic k, input logic e, input logic w);
        key = k; re = e; rw = w;
        bus0.key = k; bus0.round_end = e; bus0.round_won = w;
        bus1.key = k; bus1.round_end = e; bus1.round_won = w;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_wins[i] = 0; m_lives[i] = 0; m_hold[i] = 0;
        end
        m_keyq = 0;
    endtask

    task automatic model_tick();
        int kr;
        kr = (key && !m_keyq) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            case (m_mode[i])
                M_IDLE: if (kr != 0) m_mode[i] = M_INIT;
                M_INIT: begin
                    m_wins[i] = 0; m_lives[i] = N_LIVES; m_mode[i] = M_PLAY;
                end
                M_PLAY: if (re) begin
                    if (rw) begin
                        m_wins[i]++;
                        if (m_wins[i] % cfg_wpl[i] == 0 && m_wins[i] / cfg_wpl[i] <= MAX_LVL)
                            m_mode[i] = M_LVL;
                    end else begin
                        m_lives[i]--;
                        if (m_lives[i] == 0) begin
                            m_mode[i] = M_OVER; m_hold[i] = 0;
                        end
                    end
                end
                M_LVL: m_mode[i] = M_PLAY;
                default: begin
                    if (kr != 0 && m_hold[i] == HOLD) m_mode[i] = M_INIT;
                    else if (m_hold[i] < HOLD) m_hold[i]++;
                end
            endcase
        end
        m_keyq = key ? 1 : 0;
    endtask

    task automatic compare_inst(input int i, input int ge, input int ng, input int lu,
                                input int go, input int sc, input int lv, input int li,
                                input int sp);
        int e_lv, e_sc;
        e_lv = m_wins[i] / cfg_wpl[i];
        if (e_lv > MAX_LVL) e_lv = MAX_LVL;
        e_sc = m_wins[i];
        if (e_sc > (1 << cfg_sw[i]) - 1) e_sc = (1 << cfg_sw[i]) - 1;
        check($sformatf("i%0d_game_enable", i), ge, int'(m_mode[i] == M_PLAY));
        check($sformatf("i%0d_new_game", i), ng, int'(m_mode[i] == M_INIT));
        check($sformatf("i%0d_level_up", i), lu, int'(m_mode[i] == M_LVL));
        check($sformatf("i%0d_game_over", i), go, int'(m_mode[i] == M_OVER));
        check($sformatf("i%0d_score", i), sc, e_sc);
        check($sformatf("i%0d_level", i), lv, e_lv);
        check($sformatf("i%0d_lives", i), li, m_lives[i]);
        check($sformatf("i%0d_speed", i), sp, (BASE + e_lv > SPMAX) ? SPMAX : BASE + e_lv);
    endtask

    task automatic compare_all();
        compare_inst(0, int'(bus0.game_enable), int'(bus0.new_game), int'(bus0.level_up),
                     int'(bus0.game_over), int'(bus0.score), int'(bus0.level),
                     int'(bus0.lives), int'(bus0.target_speed));
        compare_inst(1, int'(bus1.game_enable), int'(bus1.new_game), int'(bus1.level_up),
                     int'(bus1.game_over), int'(bus1.score), int'(bus1.level),
                     int'(bus1.lives), int'(bus1.target_speed));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_tick();
        #1;
        compare_all();
        ng_cnt0 += int'(bus0.new_game);
        lu_cnt1 += int'(bus1.level_up);
    endtask

    task automatic round(input logic won);
        set_in(key, 1'b1, won);
        step();
        set_in(key, 1'b0, 1'b0);
        step();
        step();
    endtask

    initial begin
        ng_cnt0 = 0;
        lu_cnt1 = 0;
        model_reset();
        set_in(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;

        // start: key pulse at cycle 5
        repeat (3) step();
        set_in(1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (3) step();

        // level advance, then round_end landing on the LEVEL_UP cycle
        repeat (3) round(1'b1);
        set_in(1'b0, 1'b1, 1'b1);
        step();
        step();
        set_in(1'b0, 1'b0, 1'b0);
        check("i0_level_after_4_wins", int'(bus0.level), 1);
        step();

        // three losses to game over
        repeat (3) round(1'b0);
        check("i0_game_over_after_losses", int'(bus0.game_over), 1);

        // early key press is discarded, later held key starts exactly one game
        repeat (3) step();
        set_in(1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (20) step();
        ng_cnt0 = 0;
        set_in(1'b1, 1'b0, 1'b0);
        repeat (6) step();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (2) step();
        check("held_key_new_game_count", ng_cnt0, 1);
        check("i0_lives_new_game", int'(bus0.lives), 3);

        // saturation on the small instance
        lu_cnt1 = 0;
        repeat (20) round(1'b1);
        check("i1_score_sat", int'(bus1.score), 7);
        check("i1_level_sat", int'(bus1.level), 7);
        check("i1_speed_sat", int'(bus1.target_speed), 8);
        check("i1_level_up_pulses", lu_cnt1, 7);

        // asynchronous reset in mid-game, checked before any clock edge
        reset = 1'b1;
        #2;
        model_reset();
        compare_all();
        check("async_reset_enable", int'(bus0.game_enable), 0);
        repeat (2) step();
        reset = 1'b0;

        // randomized play
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom_range(0, 7) == 0) ? ~key : key,
                   $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
